// File: rtl/serial_adder_subtractor.sv
// Digit-serial two's-complement adder/subtractor.
// Handles DIGIT bits per clock, least significant digit first, so one
// operation takes N = WIDTH/DIGIT cycles. The inputs start, sub, a and b are
// read only on an IDLE cycle where start=1. Operands are held in internal
// registers, so the caller may change a, b and sub freely after that edge.
// Handshake: start is accepted only when busy=0, and an accepted start sets
// busy on the next cycle. done is a one-cycle pulse in the cycle after the
// edge that writes s/cout/ovf/zero/neg. busy is already low in that cycle, so
// a start held during the done cycle begins the next operation with no gap.
// The result registers change only at a completion edge or on reset.
module serial_adder_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             sub,
  input  logic [WIDTH-1:0]                 a,
  input  logic [WIDTH-1:0]                 b,
  output logic                             busy,
  output logic                             done,
  output logic [WIDTH-1:0]                 s,
  output logic                             cout,
  output logic                             ovf,
  output logic                             zero,
  output logic                             neg,
  // debug view: {state (1 = RUN), latched sub, digit counter}
  output logic [$clog2(WIDTH/DIGIT)+2:0]   dbg
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Reject parameter combinations that cannot split into whole digits.
  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder_subtractor: invalid WIDTH/DIGIT combination");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;     // remaining digits of A, low digit next
  logic [WIDTH-1:0] b_reg;     // remaining digits of B' (B inverted for subtract)
  logic             carry;     // carry into the next digit
  logic             sub_reg;   // operation being run, kept for debug visibility
  logic [CW-1:0]    cnt;       // index of the digit being processed

  logic [DIGIT:0]   psum;      // digit sum; top bit is the carry to the next digit
  logic [WIDTH-1:0] sum_next;  // working sum after folding in this digit
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic             last;

  // One digit of the ripple sum, with the carry held from the previous cycle.
  always_comb begin
    psum = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    last = (cnt == LAST);
  end

  if (DIGIT == WIDTH) begin : g_single
    // The whole word is one digit, so there is nothing to shift or accumulate.
    assign sum_next = psum[DIGIT-1:0];
    assign a_shift  = '0;
    assign b_shift  = '0;
  end else begin : g_multi
    // Only the upper WIDTH-DIGIT bits of the working sum survive between
    // cycles. Each new digit enters at the top, and the oldest digit moves
    // toward bit 0.
    logic [WIDTH-DIGIT-1:0] sum_hi;

    assign sum_next = {psum[DIGIT-1:0], sum_hi};
    assign a_shift  = {{DIGIT{1'b0}}, a_reg[WIDTH-1:DIGIT]};
    assign b_shift  = {{DIGIT{1'b0}}, b_reg[WIDTH-1:DIGIT]};

    // Working sum: cleared on accept, shifted once per digit while running.
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_hi <= '0;
      end else if (state == IDLE && start) begin
        sum_hi <= '0;
      end else if (state == RUN) begin
        sum_hi <= sum_next[WIDTH-1:DIGIT];
      end
    end
  end

  // Control FSM, operand shifters and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      neg     <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      carry   <= 1'b0;
      sub_reg <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtract is A + ~B + 1: invert B and set the initial carry.
            a_reg   <= a;
            b_reg   <= b ^ {WIDTH{sub}};
            carry   <= sub;
            sub_reg <= sub;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_reg <= a_shift;
          b_reg <= b_shift;
          carry <= psum[DIGIT];
          cnt   <= cnt + CW'(1);
          if (last) begin
            // On the last digit, bit DIGIT-1 of a_reg and b_reg holds the
            // operand MSBs, and psum[DIGIT-1] is the result MSB.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            s     <= sum_next;
            cout  <= psum[DIGIT];
            ovf   <= (a_reg[DIGIT-1] == b_reg[DIGIT-1]) && (psum[DIGIT-1] != a_reg[DIGIT-1]);
            zero  <= (sum_next == '0);
            neg   <= psum[DIGIT-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg = {state, sub_reg, cnt};

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Bench for serial_adder_subtractor. Five configurations run in parallel:
// WIDTH/DIGIT = 32/8, 32/1, 32/4, 32/32 and 8/2. Each configuration has its
// own reference model, which works from plain integer arithmetic and edge
// counts, and one compare process that checks every cycle. The 32/8 instance
// also runs directed cases that check hand-computed literal values.
module tb_serial_adder_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    longint      due;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  task automatic chk(input int cfg, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cfg%0d %s: got 0x%0h expected 0x%0h at %0t", cfg, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 5; g++) begin : cfg
    localparam int W  = (g == 4) ? 8 : 32;
    localparam int D  = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : (g == 3) ? 32 : 2;
    localparam int N  = W / D;
    localparam int CW = $clog2(N) + 1;

    logic         rst, start, sub;
    logic [W-1:0] a, b, s;
    logic         busy, done, cout, ovf, zero, neg;
    logic [CW+1:0] dbg;

    serial_adder_subtractor #(.WIDTH(W), .DIGIT(D)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf),
      .zero(zero), .neg(neg), .dbg(dbg)
    );

    // Reference model. An accepted start at edge E produces its result at
    // edge E+N. The model is busy while a result is still pending.
    res_t   exp_q[$];
    res_t   held    = '{default: 0};
    bit     m_valid = 0;
    bit     m_busy  = 0;
    bit     m_done  = 0;
    longint edge_cnt = 0;
    int     n_done  = 0;
    bit     fin     = 0;

    always @(posedge clk) begin : model
      logic [W:0] full;
      logic [W:0] cin;
      longint     sa, sb, r, lim;
      res_t       e;
      bit         accept;
      edge_cnt++;
      accept = m_valid && !m_busy && start && !rst;
      if (rst) begin
        exp_q.delete();
        held    = '{default: 0};
        m_done  = 0;
        m_busy  = 0;
        m_valid = 1;
      end else if (m_valid) begin
        m_done = 0;
        if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
          held   = exp_q.pop_front();
          m_done = 1;
          n_done++;
        end
        if (accept) begin
          cin    = '0;
          cin[0] = sub;
          full   = {1'b0, a} + (sub ? {1'b0, ~b} : {1'b0, b}) + cin;
          sa     = longint'($signed(a));
          sb     = longint'($signed(b));
          r      = sub ? sa - sb : sa + sb;
          lim    = longint'(1) <<< (W - 1);
          e.due  = edge_cnt + N;
          e.s    = 32'(full[W-1:0]);
          e.cout = full[W];
          e.ovf  = (r >= lim) || (r < -lim);
          e.zero = (full[W-1:0] == '0);
          e.neg  = full[W-1];
          exp_q.push_back(e);
        end
        m_busy = (exp_q.size() > 0);
      end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
      if (m_valid) begin
        chk(g, "busy",  busy, m_busy);
        chk(g, "done",  done, m_done);
        chk(g, "state", dbg[CW+1], m_busy);
        chk(g, "s",     32'(s), held.s);
        chk(g, "cout",  cout, held.cout);
        chk(g, "ovf",   ovf,  held.ovf);
        chk(g, "zero",  zero, held.zero);
        chk(g, "neg",   neg,  held.neg);
      end
    end

    function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
        0:       return '0;
        1:       return '1;
        2:       return {1'b1, {(W-1){1'b0}}};
        3:       return {1'b0, {(W-1){1'b1}}};
        default: return W'($urandom);
      endcase
    endfunction

    task automatic do_reset();
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
    endtask

    task automatic random_phase();
      while (n_done < 1000 || m_busy) begin
        @(negedge clk);
        rst   = ($urandom_range(0, 399) == 0);
        start = ($urandom_range(0, 2) != 0);
        sub   = 1'($urandom_range(0, 1));
        a     = pick();
        b     = pick();
      end
      rst = 1'b0;
      start = 1'b0;
    endtask

    if (g == 0) begin : drv0
      task automatic wait_done(output int k, output int bc);
        k = 0; bc = 0;
        while (!done && k < 40) begin
          bc += int'(busy);
          @(negedge clk);
          k++;
        end
        if (!done) chk(g, "done_seen", done, 1);
      endtask

      task automatic op(input logic [31:0] aa, input logic [31:0] bb, input logic sb,
                        input logic [31:0] es, input logic ec, input logic eo,
                        input logic ez, input logic en);
        int k, bc;
        @(negedge clk); a = aa; b = bb; sub = sb; start = 1'b1;
        @(negedge clk); start = 1'b0; a = $urandom; b = $urandom; sub = ~sb;
        wait_done(k, bc);
        chk(g, "lat",         k, N);
        chk(g, "busy_cycles", bc, N);
        chk(g, "s_lit",    s, es);
        chk(g, "cout_lit", cout, ec);
        chk(g, "ovf_lit",  ovf, eo);
        chk(g, "zero_lit", zero, ez);
        chk(g, "neg_lit",  neg, en);
      endtask

      initial begin
        int k, bc;
        do_reset();
        op(32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        op(32'h12345678, 32'h12345678, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        op(32'd3, 32'd5, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        op(32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
        op(32'hFFFFFFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        op(32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);

        // start held with new operands while busy must be ignored
        @(negedge clk); a = 32'd1; b = 32'd2; sub = 1'b0; start = 1'b1;
        @(negedge clk); a = 32'd100; b = 32'd200;
        @(negedge clk); a = 32'd300;
        @(negedge clk); start = 1'b0;
        wait_done(k, bc);
        chk(g, "ign_lat", k, N - 2);
        chk(g, "ign_s", s, 32'd3);
        repeat (N + 2) begin
          @(negedge clk);
          chk(g, "ign_no_done", done, 1'b0);
        end

        // start held through done: next operation accepted in the done cycle
        @(negedge clk); a = 32'd10; b = 32'd20; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        wait_done(k, bc);
        chk(g, "b2b_s1", s, 32'd30);
        a = 32'd7; b = 32'd9; sub = 1'b1;
        @(negedge clk); start = 1'b0; a = $urandom; b = $urandom;
        wait_done(k, bc);
        chk(g, "b2b_lat", k, N);
        chk(g, "b2b_s2", s, 32'hFFFFFFFE);
        chk(g, "b2b_neg", neg, 1'b1);

        // results hold during a following run
        @(negedge clk); a = 32'd1; b = 32'd1; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk(g, "hold_busy", busy, 1'b1);
        chk(g, "hold_s", s, 32'hFFFFFFFE);
        wait_done(k, bc);
        chk(g, "hold_s2", s, 32'd2);

        // reset sampled at the second edge of an operation
        @(negedge clk); a = 32'h11; b = 32'h22; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk(g, "rst_busy", busy, 1'b0);
        chk(g, "rst_done", done, 1'b0);
        chk(g, "rst_s",    s, 32'h0);
        chk(g, "rst_flags", {cout, ovf, zero, neg}, 4'h0);
        repeat (N + 2) begin
          @(negedge clk);
          chk(g, "rst_no_done", done, 1'b0);
        end
        op(32'h11, 32'h22, 1'b0, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0);

        random_phase();
        repeat (N + 3) @(negedge clk);
        fin = 1'b1;
      end
    end else begin : drvn
      initial begin
        do_reset();
        random_phase();
        repeat (N + 3) @(negedge clk);
        fin = 1'b1;
      end
    end
  end

  initial begin : report
    bit all_fin;
    all_fin = 1'b0;
    for (int i = 0; i < 70000 && !all_fin; i++) begin
      @(posedge clk);
      all_fin = cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin && cfg[4].fin;
    end
    if (!all_fin) chk(-1, "run_timeout", all_fin, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
